// File: rtl/sqrt16_round_unit_if.sv
// sqrt16_round_unit_if
//   Launch/complete handshake bundle for the square-root coprocessor.
//   Signals:
//     Start     - launch request, rising edge acted on (master -> slave)
//     OperandHi - operand bits [15:8]                  (master -> slave)
//     OperandLo - operand bits [7:0]                   (master -> slave)
//     Result    - rounded square root, valid while Ack (slave -> master)
//     Ack       - done flag, held until next launch    (slave -> master)
//     Busy      - computation in progress              (slave -> master)
interface sqrt16_round_unit_if #(
  parameter int RES_W = 8
);
  logic             Start;
  logic [RES_W-1:0] OperandHi;
  logic [RES_W-1:0] OperandLo;
  logic [RES_W-1:0] Result;
  logic             Ack;
  logic             Busy;

  modport master (
    output Start, OperandHi, OperandLo,
    input  Result, Ack, Busy
  );

  modport slave (
    input  Start, OperandHi, OperandLo,
    output Result, Ack, Busy
  );
endinterface

// File: rtl/sqrt16_round_unit.sv
// sqrt16_round_unit
//   Sequential integer square-root coprocessor. Latches a 16-bit operand on a
//   Start rising edge, computes one root bit per clock with restoring
//   digit-by-digit square root (8 CALC cycles), then spends one ROUND cycle
//   producing the round-half-up result saturated at 8'hFF. Fixed latency of
//   9 cycles from launch edge to Ack.
//   Ports:
//     Clk   - rising-edge clock
//     Reset - synchronous active-high reset
//     bus   - sqrt16_round_unit_if.slave (Start, OperandHi/Lo, Result, Ack, Busy)
//   Build option:
//     SQRT_FLOOR_EN - when defined, Result is the truncated root (no rounding);
//                     latency and handshake unchanged.
module sqrt16_round_unit #(
  parameter int OP_W = 16
) (
  input logic                Clk,
  input logic                Reset,
  sqrt16_round_unit_if.slave bus
);

  localparam int RES_W = OP_W / 2;
  localparam int REM_W = RES_W + 2;
  localparam int IT_W  = $clog2(RES_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IT_W-1:0]  ITER_MAX = IT_W'(RES_W - 1);
  localparam logic [IT_W-1:0]  ITER_ONE = IT_W'(1);
  localparam logic [RES_W-1:0] ROOT_ONE = RES_W'(1);

  logic [1:0]       state_q,  state_d;
  logic             start_q,  start_d;
  logic [OP_W-1:0]  x_q,      x_d;
  logic [REM_W-1:0] rem_q,    rem_d;
  logic [RES_W-1:0] root_q,   root_d;
  logic [IT_W-1:0]  iter_q,   iter_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             ack_q,    ack_d;

  logic             launch;
  logic [REM_W-1:0] rem_sh;
  logic [REM_W-1:0] trial;

  // Launch only on a Start rising edge while not computing.
  assign launch = bus.Start && !start_q &&
                  ((state_q == S_IDLE) || (state_q == S_DONE));

  // rem before the shift never exceeds 2*root with root < 2^(RES_W-1) during
  // CALC, so dropping its top two bits on the shift loses nothing.
  assign rem_sh = {rem_q[RES_W-1:0], x_q[OP_W-1 -: 2]};
  assign trial  = {root_q, 2'b01};

  always_comb begin
    state_d  = state_q;
    start_d  = bus.Start;
    x_d      = x_q;
    rem_d    = rem_q;
    root_d   = root_q;
    iter_d   = iter_q;
    result_d = result_q;
    ack_d    = ack_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (launch) begin
          x_d     = {bus.OperandHi, bus.OperandLo};
          rem_d   = '0;
          root_d  = '0;
          iter_d  = ITER_MAX;
          ack_d   = 1'b0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        x_d = {x_q[OP_W-3:0], 2'b00};
        if (rem_sh >= trial) begin
          rem_d  = rem_sh - trial;
          root_d = {root_q[RES_W-2:0], 1'b1};
        end else begin
          rem_d  = rem_sh;
          root_d = {root_q[RES_W-2:0], 1'b0};
        end
        if (iter_q == '0) begin
          state_d = S_ROUND;
        end else begin
          iter_d = iter_q - ITER_ONE;
        end
      end
      S_ROUND: begin
`ifdef SQRT_FLOOR_EN
        result_d = root_q;
`else
        // Remainder above the root means x >= (f+0.5)^2, i.e. round up.
        if ((rem_q > {2'b00, root_q}) && (root_q != '1)) begin
          result_d = root_q + ROOT_ONE;
        end else begin
          result_d = root_q;
        end
`endif
        ack_d   = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      x_q      <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      iter_q   <= '0;
      result_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      x_q      <= x_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      iter_q   <= iter_d;
      result_q <= result_d;
      ack_q    <= ack_d;
    end
  end

  assign bus.Result = result_q;
  assign bus.Ack    = ack_q;
  assign bus.Busy   = (state_q == S_CALC) || (state_q == S_ROUND);

endmodule

// File: tb/tb_sqrt16_round_unit.sv
// Directed testbench for sqrt16_round_unit.
module tb_sqrt16_round_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sqrt16_round_unit_if #(.RES_W(8)) bus ();

  sqrt16_round_unit #(.OP_W(16)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.Start     = 1'b1;
    bus.OperandHi = 8'h00;
    bus.OperandLo = 8'h90;
    tick();
    checks++;
    if (bus.Result !== 8'h00 || bus.Ack !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: Result=%h Ack=%b Busy=%b want 00 0 0",
               bus.Result, bus.Ack, bus.Busy);
    end
    rst = 1'b0;
    tick();  // launch edge: Start held through reset counts
    checks++;
    if (bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_launch_busy: Busy=%b want 1", bus.Busy);
    end
    bus.Start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (bus.Ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_launch_early_ack: Ack=%b want 0 at edge k+8", bus.Ack);
    end
    tick();
    checks++;
    if (bus.Ack !== 1'b1 || bus.Busy !== 1'b0 || bus.Result !== 8'h0C) begin
      errors++;
      $display("FAIL reset_launch_result: Ack=%b Busy=%b Result=%h want 1 0 0c",
               bus.Ack, bus.Busy, bus.Result);
    end
  endtask

  task automatic test_rounding();
    logic [15:0] ops   [4] = '{16'd156, 16'd157, 16'd2, 16'd3};
`ifdef SQRT_FLOOR_EN
    logic [7:0]  exps  [4] = '{8'd12, 8'd12, 8'd1, 8'd1};
`else
    logic [7:0]  exps  [4] = '{8'd12, 8'd13, 8'd1, 8'd2};
`endif
    for (int v = 0; v < 4; v++) begin
      bus.OperandHi = ops[v][15:8];
      bus.OperandLo = ops[v][7:0];
      bus.Start     = 1'b1;
      tick();
      bus.Start     = 1'b0;
      bus.OperandHi = 8'hA5;  // post-launch operand changes must not matter
      bus.OperandLo = 8'h5A;
      checks++;
      if (bus.Ack !== 1'b0 || bus.Busy !== 1'b1) begin
        errors++;
        $display("FAIL round_launch[%0d]: Ack=%b Busy=%b want 0 1", v, bus.Ack, bus.Busy);
      end
      for (int i = 0; i < 9; i++) tick();
      checks++;
      if (bus.Ack !== 1'b1 || bus.Result !== exps[v]) begin
        errors++;
        $display("FAIL round_result[%0d] op=%0d: Ack=%b Result=%0d want 1 %0d",
                 v, ops[v], bus.Ack, bus.Result, exps[v]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] ops  [3] = '{16'hFFFF, 16'hFF00, 16'h0000};
    logic [7:0]  exps [3] = '{8'hFF, 8'hFF, 8'h00};
    for (int v = 0; v < 3; v++) begin
      bus.OperandHi = ops[v][15:8];
      bus.OperandLo = ops[v][7:0];
      bus.Start     = 1'b1;
      tick();
      bus.Start = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (bus.Ack !== 1'b0) begin
        errors++;
        $display("FAIL sat_early_ack[%0d]: Ack=%b want 0", v, bus.Ack);
      end
      tick();
      checks++;
      if (bus.Ack !== 1'b1 || bus.Result !== exps[v]) begin
        errors++;
        $display("FAIL sat_result[%0d] op=%h: Ack=%b Result=%h want 1 %h",
                 v, ops[v], bus.Ack, bus.Result, exps[v]);
      end
    end
  endtask

  task automatic test_ignore_busy_start();
    bus.OperandHi = 8'h01;  // 400 -> 20
    bus.OperandLo = 8'h90;
    bus.Start     = 1'b1;
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bus.OperandHi = 8'h00;  // 3, would give 2
    bus.OperandLo = 8'h03;
    bus.Start     = 1'b1;
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.Ack !== 1'b0 || bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_early: Ack=%b Busy=%b want 0 1", bus.Ack, bus.Busy);
    end
    tick();
    checks++;
    if (bus.Ack !== 1'b1 || bus.Result !== 8'd20) begin
      errors++;
      $display("FAIL busy_start_result: Ack=%b Result=%0d want 1 20", bus.Ack, bus.Result);
    end
  endtask

  task automatic test_reset_mid_calc();
    bus.OperandHi = 8'h01;
    bus.OperandLo = 8'h90;
    bus.Start     = 1'b1;
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.Ack !== 1'b0 || bus.Busy !== 1'b0 || bus.Result !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_state: Ack=%b Busy=%b Result=%h want 0 0 00",
               bus.Ack, bus.Busy, bus.Result);
    end
    rst = 1'b0;
    tick();
    bus.OperandHi = 8'h01;
    bus.OperandLo = 8'h00;
    bus.Start     = 1'b1;
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (bus.Ack !== 1'b1 || bus.Result !== 8'h10) begin
      errors++;
      $display("FAIL mid_reset_relaunch: Ack=%b Result=%h want 1 10", bus.Ack, bus.Result);
    end
  endtask

  task automatic test_start_hold();
    bus.OperandHi = 8'h00;  // 81 -> 9
    bus.OperandLo = 8'h51;
    bus.Start     = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (bus.Ack !== 1'b1 || bus.Result !== 8'd9) begin
      errors++;
      $display("FAIL hold_result: Ack=%b Result=%0d want 1 9", bus.Ack, bus.Result);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.Ack !== 1'b1 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_relaunch: Ack=%b Busy=%b want 1 0", bus.Ack, bus.Busy);
    end
    bus.Start = 1'b0;
    tick();
    bus.OperandHi = 8'h00;  // 64 -> 8
    bus.OperandLo = 8'h40;
    bus.Start     = 1'b1;
    tick();
    bus.Start = 1'b0;
    checks++;
    if (bus.Ack !== 1'b0 || bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL relaunch_ack_drop: Ack=%b Busy=%b want 0 1", bus.Ack, bus.Busy);
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (bus.Ack !== 1'b0) begin
      errors++;
      $display("FAIL relaunch_early_ack: Ack=%b want 0", bus.Ack);
    end
    tick();
    checks++;
    if (bus.Ack !== 1'b1 || bus.Result !== 8'd8) begin
      errors++;
      $display("FAIL relaunch_result: Ack=%b Result=%0d want 1 8", bus.Ack, bus.Result);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.Start     = 1'b0;
    bus.OperandHi = 8'h00;
    bus.OperandLo = 8'h00;
    tick();
    test_reset();
    test_rounding();
    test_saturation();
    test_ignore_busy_start();
    test_reset_mid_calc();
    test_start_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
